match_logger: RTL and testbench

Downstream consumer of the serial sequence detector's match output `y`. Every clock is one serial bit time. The block keeps a free-running bit-position counter and a saturating match counter. It logs the bit position of each match into a small first-word-fall-through FIFO, which a host drains over a valid/ready handshake. Matches that arrive while the FIFO is full are dropped and flagged.

---
 rtl/fsm_pkg.sv | 10 +
 rtl/match_logger_if.sv | 13 +
 rtl/pos_fifo.sv | 64 ++++++
 rtl/match_logger.sv | 71 +++++++
 tb/tb_match_logger.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fsm_pkg.sv
// Shared constants and types for the match logging slice.
package fsm_pkg;

  localparam int POS_W_DEF = 16;
  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 4;

  typedef logic [POS_W_DEF-1:0] pos_t;

endpackage

// File: rtl/match_logger_if.sv
// Host-side valid/ready channel carrying logged match positions.
interface match_logger_if #(
  parameter int POS_W = fsm_pkg::POS_W_DEF
);

  logic             pos_valid;
  logic             pos_ready;
  logic [POS_W-1:0] pos_data;

  modport master (output pos_valid, output pos_data, input pos_ready);
  modport slave  (input pos_valid, input pos_data, output pos_ready);

endinterface

// File: rtl/pos_fifo.sv
// First-word-fall-through FIFO; head is read combinationally from storage.
module pos_fifo
  import fsm_pkg::*;
#(
  parameter int  DEPTH  = DEPTH_DEF,
  parameter type data_t = pos_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  data_t                  push_data,
  input  logic                   pop,
  output data_t                  head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  data_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          do_push;
  logic          do_pop;

  assign full  = (level_reg == (AW+1)'(DEPTH));
  assign empty = (level_reg == '0);

  // A push into a full FIFO is only accepted when the head leaves this cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (do_push && !do_pop)
        level_reg <= level_reg + (AW+1)'(1);
      else if (!do_push && do_pop)
        level_reg <= level_reg - (AW+1)'(1);
    end
  end

  // Storage carries no reset; emptied pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (do_push && !clear)
      mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign level = level_reg;

endmodule

// File: rtl/match_logger.sv
// Logs the bit position of every detector match into a small FIFO and keeps
// a saturating match count plus a sticky drop flag.
module match_logger
  import fsm_pkg::*;
#(
  parameter int POS_W = POS_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   y,
  input  logic                   clear,
  match_logger_if.master         pos,
  output logic [CNT_W-1:0]       match_count,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);

  logic [POS_W-1:0] bit_pos_reg;
  logic [CNT_W-1:0] match_count_reg;
  logic             overflow_reg;
  logic [POS_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  // y feeds the push directly so the Mealy pulse is used at the edge it is sampled.
  pos_fifo #(
    .DEPTH  (DEPTH),
    .data_t (logic [POS_W-1:0])
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (y),
    .push_data (bit_pos_reg),
    .pop       (pos.pos_ready),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Full implies non-empty, so a ready host always frees a slot this cycle.
  assign drop = y && fifo_full && !pos.pos_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_pos_reg     <= '0;
      match_count_reg <= '0;
      overflow_reg    <= 1'b0;
    end else if (clear) begin
      bit_pos_reg     <= '0;
      match_count_reg <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      bit_pos_reg <= bit_pos_reg + POS_W'(1);
      if (y && (match_count_reg != '1))
        match_count_reg <= match_count_reg + CNT_W'(1);
      if (drop)
        overflow_reg <= 1'b1;
    end
  end

  assign pos.pos_valid = !fifo_empty;
  assign pos.pos_data  = fifo_head;
  assign match_count   = match_count_reg;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_match_logger.sv
// Self-checking bench for match_logger: vector table plus scoreboard of logged positions.
module tb_match_logger;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        y = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] match_count;
  logic [2:0]  fifo_level;
  logic        overflow;

  match_logger_if #(.POS_W(16)) bus ();

  match_logger #(.POS_W(16), .CNT_W(16), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .y           (y),
    .clear       (clear),
    .pos         (bus.master),
    .match_count (match_count),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [15:0] q[$];
  logic [15:0] m_bp;
  logic [15:0] m_cnt;
  logic        m_ovf;
  logic [15:0] last_pop;

  typedef struct {
    logic        y;
    logic        rdy;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [2:0]  exp_level;
    logic [15:0] exp_cnt;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_bp  = '0;
    m_cnt = '0;
    m_ovf = 1'b0;
  endtask

  // Called at a falling edge; leaves at the next falling edge.
  task automatic step(input logic yi, input logic ri, input logic ci, input bit do_chk);
    y             = yi;
    bus.pos_ready = ri;
    clear         = ci;
    #1;
    if (ci) begin
      model_reset();
    end else begin
      if (ri && (q.size() > 0)) begin
        if (do_chk) chk("pop_data", bus.pos_data, q[0]);
        last_pop = q.pop_front();
      end
      if (yi) begin
        if (q.size() < DEPTH) q.push_back(m_bp);
        else m_ovf = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      m_bp++;
    end
    @(posedge clk);
    #1;
    if (do_chk) begin
      chk("valid", bus.pos_valid, (q.size() > 0));
      chk("level", fifo_level, q.size());
      chk("count", match_count, m_cnt);
      chk("overflow", overflow, m_ovf);
      if (q.size() > 0) chk("head", bus.pos_data, q[0]);
    end
    @(negedge clk);
  endtask

  // Asserted between edges; outputs must fall without waiting for a clock.
  task automatic async_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", bus.pos_valid, 1'b0);
    chk("rst_level", fifo_level, 3'd0);
    chk("rst_count", match_count, 16'd0);
    chk("rst_ovf", overflow, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.pos_ready = 1'b0;
    model_reset();
    last_pop = '0;

    //            y  rdy v  data    lvl  cnt     ovf
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 16'd0,  3'd0, 16'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'd0,  3'd0, 16'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'd0,  3'd0, 16'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 16'd3,  3'd1, 16'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'd0,  3'd0, 16'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'd0,  3'd0, 16'd1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'd0,  3'd0, 16'd1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 16'd7,  3'd1, 16'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'd0,  3'd0, 16'd2, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'd0,  3'd0, 16'd2, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 16'd10, 3'd1, 16'd3, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 16'd10, 3'd2, 16'd4, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 16'd10, 3'd3, 16'd5, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 16'd10, 3'd4, 16'd6, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 16'd10, 3'd4, 16'd7, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 16'd11, 3'd3, 16'd7, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 16'd12, 3'd2, 16'd7, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 16'd13, 3'd1, 16'd7, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 16'd0,  3'd0, 16'd7, 1'b1};

    @(negedge clk);
    chk("init_valid", bus.pos_valid, 1'b0);
    chk("init_level", fifo_level, 3'd0);
    chk("init_count", match_count, 16'd0);
    chk("init_ovf", overflow, 1'b0);
    reset = 1'b0;

    // Positions 3 and 7, then an overflowing burst at 10..14 and a drain
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].y, tbl[i].rdy, 1'b0, 1'b1);
      chk($sformatf("tbl%0d_valid", i), bus.pos_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), bus.pos_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].exp_level);
      chk($sformatf("tbl%0d_count", i), match_count, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].exp_ovf);
      $display("vec %0d y=%0b rdy=%0b -> valid=%0b data=%0d level=%0d count=%0d ovf=%0b",
               i, tbl[i].y, tbl[i].rdy, bus.pos_valid, bus.pos_data, fifo_level, match_count, overflow);
    end

    // Three queued entries, then clear together with a match
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("clr_level", fifo_level, 3'd0);
    chk("clr_valid", bus.pos_valid, 1'b0);
    chk("clr_count", match_count, 16'd0);
    chk("clr_ovf", overflow, 1'b0);
    $display("clear: level=%0d valid=%0b count=%0d ovf=%0b", fifo_level, bus.pos_valid, match_count, overflow);

    // Fill at 16..19, then push+pop on full at 20
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("full_head", bus.pos_data, 16'd16);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("fullpp_level", fifo_level, 3'd4);
    chk("fullpp_ovf", overflow, 1'b0);
    $display("full push+pop: level=%0d ovf=%0b", fifo_level, overflow);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("fullpp_last", last_pop, 16'd20);
    $display("drain: last entry=%0d", last_pop);

    // Async reset with two entries queued
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    async_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("post_rst_pos", bus.pos_data, 16'd0);
    $display("after reset: first logged pos=%0d", bus.pos_data);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // Continuous matches: bit position wraps and the count saturates
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 65540; k++) begin
      step(1'b1, 1'b1, 1'b0, (k > 65530));
      if (k == 65535) chk("sat_reach", match_count, 16'hFFFF);
      if (k == 65538) chk("wrap_pos", bus.pos_data, 16'd1);
    end
    chk("sat_hold", match_count, 16'hFFFF);
    chk("wrap_ovf", overflow, 1'b0);
    $display("long run: count=%0h head=%0d", match_count, bus.pos_data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
